// File: rtl/retire_pair_pkg.sv
// rtl/retire_pair_pkg.sv - retirement record type shared by the pairing buffer
package retire_pair_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic        trap;
    } retire_rec_t;

    localparam int REC_W = $bits(retire_rec_t);

endpackage

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - single-clock show-ahead FIFO with flush and occupancy
module retire_fifo
    import retire_pair_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = REC_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   occ_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         push_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign occ_o   = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
    assign push_ok = push_i && (!full_o || pop_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/retire_pair.sv
// rtl/retire_pair.sv - lock-step pairing of two cores' retirement streams
module retire_pair
    import retire_pair_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      retire_1_i,
    input  retire_rec_t               rec_1_i,
    input  logic                      retire_2_i,
    input  retire_rec_t               rec_2_i,
    output logic                      pair_valid_o,
    input  logic                      pair_ready_i,
    output retire_rec_t               pair_rec_1_o,
    output retire_rec_t               pair_rec_2_o,
    output logic [$clog2(DEPTH)+1:0]  skew_o,
    output logic                      overflow_o,
    output logic [CNT_W-1:0]          pair_count_o
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic          full_1, empty_1, full_2, empty_2;
    logic [OW-1:0] occ_1, occ_2;
    logic          pop;
    logic          overflow_q, overflow_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;

    assign pair_valid_o = !empty_1 && !empty_2;
    assign pop          = pair_valid_o && pair_ready_i;
    assign skew_o       = {1'b0, occ_1} - {1'b0, occ_2};
    assign overflow_o   = overflow_q;
    assign pair_count_o = pair_count_q;

    retire_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo_1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (retire_1_i),
        .data_i  (rec_1_i),
        .pop_i   (pop),
        .data_o  (pair_rec_1_o),
        .full_o  (full_1),
        .empty_o (empty_1),
        .occ_o   (occ_1)
    );

    retire_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo_2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (retire_2_i),
        .data_i  (rec_2_i),
        .pop_i   (pop),
        .data_o  (pair_rec_2_o),
        .full_o  (full_2),
        .empty_o (empty_2),
        .occ_o   (occ_2)
    );

    // Flush wins over everything: discarded pushes never count as drops and pops are not counted.
    always_comb begin
        overflow_d   = overflow_q;
        pair_count_d = pair_count_q;
        if (flush_i) begin
            overflow_d = 1'b0;
        end else begin
            if (!pop && ((retire_1_i && full_1) || (retire_2_i && full_2))) begin
                overflow_d = 1'b1;
            end
            if (pop) begin
                pair_count_d = pair_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q   <= 1'b0;
            pair_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            pair_count_q <= pair_count_d;
        end
    end

endmodule

// File: tb/tb_retire_pair.sv
// tb/tb_retire_pair.sv - randomized self-checking bench for retire_pair
module tb_retire_pair;
    import retire_pair_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        retire_1_i = 1'b0;
    logic        retire_2_i = 1'b0;
    logic        pair_ready_i = 1'b0;
    retire_rec_t rec_1_i = '0;
    retire_rec_t rec_2_i = '0;

    logic        pair_valid_o;
    retire_rec_t pair_rec_1_o, pair_rec_2_o;
    logic [3:0]  skew_o;
    logic        overflow_o;
    logic [31:0] pair_count_o;

    logic        s_valid;
    retire_rec_t s_rec_1, s_rec_2;
    logic [3:0]  s_skew;
    logic        s_overflow;
    logic [1:0]  s_count;

    int checks = 0;
    int failures = 0;

    retire_rec_t q1[$];
    retire_rec_t q2[$];
    bit          m_ovf = 0;
    logic [31:0] m_count = '0;

    retire_pair #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .retire_1_i(retire_1_i), .rec_1_i(rec_1_i),
        .retire_2_i(retire_2_i), .rec_2_i(rec_2_i),
        .pair_valid_o(pair_valid_o), .pair_ready_i(pair_ready_i),
        .pair_rec_1_o(pair_rec_1_o), .pair_rec_2_o(pair_rec_2_o),
        .skew_o(skew_o), .overflow_o(overflow_o), .pair_count_o(pair_count_o)
    );

    retire_pair #(.DEPTH(DEPTH), .CNT_W(2)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .retire_1_i(retire_1_i), .rec_1_i(rec_1_i),
        .retire_2_i(retire_2_i), .rec_2_i(rec_2_i),
        .pair_valid_o(s_valid), .pair_ready_i(pair_ready_i),
        .pair_rec_1_o(s_rec_1), .pair_rec_2_o(s_rec_2),
        .skew_o(s_skew), .overflow_o(s_overflow), .pair_count_o(s_count)
    );

    always #5 clk_i = ~clk_i;

    function automatic retire_rec_t rnd_rec();
        retire_rec_t r;
        r.insn      = $urandom;
        r.pc_wdata  = $urandom;
        r.rd_addr   = 5'($urandom);
        r.rd_wdata  = $urandom;
        r.mem_addr  = $urandom;
        r.mem_rmask = 4'($urandom);
        r.mem_wmask = 4'($urandom);
        r.trap      = 1'($urandom);
        return r;
    endfunction

    function automatic retire_rec_t insn_rec(input logic [31:0] insn);
        retire_rec_t r;
        r = '0;
        r.insn = insn;
        return r;
    endfunction

    function automatic logic [3:0] m_skew();
        return 4'(q1.size() - q2.size());
    endfunction

    function automatic bit m_valid();
        return (q1.size() > 0) && (q2.size() > 0);
    endfunction

    // Drive one cycle from a negedge, advance the reference queues at the posedge, return at the next negedge.
    task automatic cyc(input bit r1, input retire_rec_t d1, input bit r2, input retire_rec_t d2,
                       input bit rdy, input bit fl);
        bit pop;
        retire_1_i = r1; rec_1_i = d1; retire_2_i = r2; rec_2_i = d2;
        pair_ready_i = rdy; flush_i = fl;
        pop = m_valid() && rdy;
        @(posedge clk_i);
        if (fl) begin
            q1.delete(); q2.delete(); m_ovf = 0;
        end else begin
            if (pop) begin
                void'(q1.pop_front()); void'(q2.pop_front()); m_count = m_count + 1;
            end
            if (r1) begin
                if (q1.size() < DEPTH) q1.push_back(d1); else m_ovf = 1;
            end
            if (r2) begin
                if (q2.size() < DEPTH) q2.push_back(d2); else m_ovf = 1;
            end
        end
        @(negedge clk_i);
        retire_1_i = 0; retire_2_i = 0; flush_i = 0; pair_ready_i = 0;
    endtask

    task automatic model_reset();
        q1.delete(); q2.delete(); m_ovf = 0; m_count = '0;
    endtask

    task automatic test_reset();
        checks++; if (pair_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", pair_valid_o); end
        checks++; if (skew_o !== 4'd0) begin failures++; $display("FAIL reset_skew got=%0h exp=0", skew_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow_o); end
        checks++; if (pair_count_o !== 32'd0) begin failures++; $display("FAIL reset_count got=%0h exp=0", pair_count_o); end
        checks++; if (pair_rec_1_o !== retire_rec_t'(0)) begin failures++; $display("FAIL reset_rec1 got=%0h exp=0", pair_rec_1_o); end
        checks++; if (pair_rec_2_o !== retire_rec_t'(0)) begin failures++; $display("FAIL reset_rec2 got=%0h exp=0", pair_rec_2_o); end
    endtask

    task automatic test_skew_latency();
        logic        exp_v;
        logic [3:0]  exp_s;
        logic [31:0] exp_c;
        for (int c = 1; c <= 6; c++) begin
            cyc(c == 1, insn_rec(32'h13), c == 4, insn_rec(32'h13), 1'b1, 1'b0);
            exp_v = (c == 4);
            exp_s = (c <= 3) ? 4'd1 : 4'd0;
            exp_c = (c >= 5) ? 32'd1 : 32'd0;
            checks++; if (pair_valid_o !== exp_v) begin failures++; $display("FAIL lat_valid c=%0d got=%0b exp=%0b", c, pair_valid_o, exp_v); end
            checks++; if (skew_o !== exp_s) begin failures++; $display("FAIL lat_skew c=%0d got=%0h exp=%0h", c, skew_o, exp_s); end
            checks++; if (pair_count_o !== exp_c) begin failures++; $display("FAIL lat_count c=%0d got=%0h exp=%0h", c, pair_count_o, exp_c); end
            if (exp_v) begin
                checks++; if (pair_rec_1_o.insn !== 32'h13 || pair_rec_2_o.insn !== 32'h13) begin
                    failures++; $display("FAIL lat_insn got=%0h/%0h exp=13/13", pair_rec_1_o.insn, pair_rec_2_o.insn); end
            end
        end
    endtask

    task automatic test_overflow();
        retire_rec_t st[5];
        for (int i = 0; i < 5; i++) begin
            st[i] = rnd_rec();
            cyc(1'b1, st[i], 1'b0, '0, 1'b0, 1'b0);
        end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow_o); end
        checks++; if (skew_o !== 4'd4) begin failures++; $display("FAIL ovf_skew got=%0h exp=4", skew_o); end
        checks++; if (pair_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_valid got=%0b exp=0", pair_valid_o); end
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, rnd_rec(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (pair_valid_o !== 1'b1 || pair_rec_1_o !== st[i]) begin
                failures++; $display("FAIL ovf_order i=%0d valid=%0b got=%0h exp=%0h", i, pair_valid_o, pair_rec_1_o, st[i]); end
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (pair_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0b exp=0", pair_valid_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow_o); end
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        for (int i = 0; i < 2; i++) cyc(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b0, 1'b0);
        cnt_before = m_count;
        cyc(1'b1, rnd_rec(), 1'b0, '0, 1'b1, 1'b1);
        checks++; if (pair_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", pair_valid_o); end
        checks++; if (skew_o !== 4'd0) begin failures++; $display("FAIL flush_skew got=%0h exp=0", skew_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL flush_overflow got=%0b exp=0", overflow_o); end
        checks++; if (pair_count_o !== cnt_before) begin failures++; $display("FAIL flush_count got=%0h exp=%0h", pair_count_o, cnt_before); end
        cyc(1'b0, '0, 1'b1, rnd_rec(), 1'b0, 1'b0);
        checks++; if (pair_valid_o !== 1'b0 || skew_o !== 4'hF) begin
            failures++; $display("FAIL flush_discard valid=%0b skew=%0h exp valid=0 skew=f", pair_valid_o, skew_o); end
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b0, 1'b0);
        cyc(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b1, 1'b0);
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL full_ovf got=%0b exp=0", overflow_o); end
        checks++; if (skew_o !== 4'd0 || pair_valid_o !== 1'b1) begin
            failures++; $display("FAIL full_state skew=%0h valid=%0b exp skew=0 valid=1", skew_o, pair_valid_o); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (pair_valid_o !== 1'b1 || pair_rec_1_o !== q1[0] || pair_rec_2_o !== q2[0]) begin
                failures++; $display("FAIL full_order i=%0d valid=%0b got=%0h exp=%0h", i, pair_valid_o, pair_rec_1_o, q1[0]); end
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (pair_valid_o !== 1'b0) begin failures++; $display("FAIL full_drained got=%0b exp=0", pair_valid_o); end
    endtask

    task automatic test_count_wrap();
        logic [31:0] start;
        start = m_count;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b0, 1'b0);
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            checks++; if (s_count !== m_count[1:0]) begin failures++; $display("FAIL wrap_small i=%0d got=%0h exp=%0h", i, s_count, m_count[1:0]); end
        end
        checks++; if (pair_count_o !== start + 32'd5) begin failures++; $display("FAIL wrap_main got=%0h exp=%0h", pair_count_o, start + 32'd5); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b0, 1'b0);
        checks++; if (pair_valid_o !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0b exp=1", pair_valid_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (pair_valid_o !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0b exp=0", pair_valid_o); end
        checks++; if (skew_o !== 4'd0 || overflow_o !== 1'b0) begin failures++; $display("FAIL areset_flags skew=%0h ovf=%0b exp 0/0", skew_o, overflow_o); end
        checks++; if (pair_count_o !== 32'd0) begin failures++; $display("FAIL areset_count got=%0h exp=0", pair_count_o); end
        checks++; if (pair_rec_1_o !== retire_rec_t'(0) || pair_rec_2_o !== retire_rec_t'(0)) begin
            failures++; $display("FAIL areset_rec got=%0h/%0h exp=0", pair_rec_1_o, pair_rec_2_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        bit r1, r2, rdy, fl;
        for (int n = 0; n < 400; n++) begin
            checks++; if (pair_valid_o !== m_valid()) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, pair_valid_o, m_valid()); end
            checks++; if (skew_o !== m_skew()) begin failures++; $display("FAIL rnd_skew n=%0d got=%0h exp=%0h", n, skew_o, m_skew()); end
            checks++; if (overflow_o !== m_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%0b exp=%0b", n, overflow_o, m_ovf); end
            checks++; if (pair_count_o !== m_count || s_count !== m_count[1:0]) begin
                failures++; $display("FAIL rnd_count n=%0d got=%0h/%0h exp=%0h", n, pair_count_o, s_count, m_count); end
            if (m_valid()) begin
                checks++; if (pair_rec_1_o !== q1[0] || pair_rec_2_o !== q2[0]) begin
                    failures++; $display("FAIL rnd_rec n=%0d got=%0h/%0h exp=%0h/%0h", n, pair_rec_1_o, pair_rec_2_o, q1[0], q2[0]); end
            end
            r1  = ($urandom_range(0, 99) < 45);
            r2  = ($urandom_range(0, 99) < 45);
            rdy = ($urandom_range(0, 99) < 40);
            fl  = ($urandom_range(0, 99) < 3);
            cyc(r1, rnd_rec(), r2, rnd_rec(), rdy, fl);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        test_reset();
        test_skew_latency();
        test_overflow();
        test_flush();
        test_full_pushpop();
        test_count_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/retire_pair.md
Name: retire_pair

Overview:
- Sits between the two RVFI retirement ports of the dual-core harness and the contract checker.
- Buffers each core's retirement records in its own FIFO and releases them strictly in lock-step pairs (record k of core 1 with record k of core 2).
- Lets the cores retire at different cycles without losing alignment.
- Exposes skew, pair count and a sticky overflow flag so the harness can tell when the pairing is no longer valid.

Parameters:
- DEPTH, 4, entries per core FIFO; power of two, at least 2.
- CNT_W, 32, width of pair_count_o.

Ports:
- clk_i  in  1  harness clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  synchronous clear of both FIFOs and of overflow_o
- retire_1_i  in  1  core 1 retires this cycle
- rec_1_i  in  $bits(retire_rec_t)  core 1 retirement record
- retire_2_i  in  1  core 2 retires this cycle
- rec_2_i  in  $bits(retire_rec_t)  core 2 retirement record
- pair_valid_o  out  1  both FIFO heads are valid
- pair_ready_i  in  1  consumer accepts the current pair
- pair_rec_1_o  out  $bits(retire_rec_t)  core 1 head record
- pair_rec_2_o  out  $bits(retire_rec_t)  core 2 head record
- skew_o  out  $clog2(DEPTH)+2  signed occupancy_1 minus occupancy_2
- overflow_o  out  1  sticky; a record was dropped
- pair_count_o  out  CNT_W  pairs consumed since reset; wraps around

Behaviour:
- Reset (asynchronous, active-high): both FIFOs empty, pointers 0, pair_valid_o=0, skew_o=0, overflow_o=0, pair_count_o=0, rec outputs 0.
- Push, per core n: when retire_n_i=1 and FIFO n is not full, rec_n_i is written at the write pointer.
- Full FIFO and no pop this cycle: the record is dropped and overflow_o is set to 1 on the next edge.
- Full FIFO and a pop in the same cycle: the push is accepted and occupancy is unchanged.
- Pop: pop = pair_valid_o & pair_ready_i. A pop removes the head of both FIFOs in the same cycle; the FIFOs are never popped individually.
- Output timing:
  - pair_valid_o = !empty_1 & !empty_2, driven from registered occupancy.
  - No bypass: a record pushed at edge t is first visible after edge t.
  - Minimum latency from push to output is 1 cycle.
- Head outputs: show-ahead. pair_rec_n_o is the memory at the read pointer, valid only while pair_valid_o=1. Its contents are don't-care otherwise.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. full = MSBs differ and lower bits equal; empty = pointers equal.
- pair_count_o: increments by 1 on each pop; wraps from 2^CNT_W-1 to 0.
- skew_o: occ_1 - occ_2 in two's complement, updated each cycle from registered occupancy. Range is -DEPTH..+DEPTH.
- flush_i:
  - Next edge: both FIFOs empty and overflow_o=0.
  - Has priority over push and pop in the same cycle; such pushes are discarded and do not set overflow.
  - pair_count_o is unchanged.
- A simultaneous push on both cores into empty FIFOs gives pair_valid_o=1 on the next cycle.
- Reset asserted mid-operation clears all state immediately; partial pairs are discarded.
- No combinational path from retire_n_i or rec_n_i to any output. pair_ready_i feeds only the next-state logic.

Decomposition:
- Package retire_pair_pkg holds:
  - typedef retire_rec_t, packed: insn[31:0], pc_wdata[31:0], rd_addr[4:0], rd_wdata[31:0], mem_addr[31:0], mem_rmask[3:0], mem_wmask[3:0], trap; 142 bits total.
  - Localparam REC_W = $bits(retire_rec_t).
- Sub-module retire_fifo: single-clock show-ahead FIFO with push, pop, flush, full, empty and occupancy. It is instantiated twice; retire_pair holds the pairing, skew and counter logic.

Test Plan (DEPTH=4):
- Core 1 retires insn 0x00000013 at cycle 1; core 2 retires 0x00000013 at cycle 4; pair_ready_i=1 -> pair_valid_o=1 only at cycle 5; skew_o goes 1 and holds through cycle 4, then 0 after the pop; pair_count_o=1.
- Core 1 pushes 5 records while core 2 is idle and pair_ready_i=0 -> records 1-4 are stored, the 5th is dropped, overflow_o=1, skew_o=4.
- Both FIFOs full, both cores push and pair_ready_i=1 in the same cycle -> both pushes are accepted, occupancy stays 4, overflow_o stays 0, the pair order is preserved.
- Both cores hold 2 entries; assert flush_i together with retire_1_i -> next cycle both FIFOs are empty, pair_valid_o=0, overflow_o=0, pair_count_o is unchanged.
- Preload pair_count_o to 0xFFFFFFFF via a force/backdoor, then consume one pair -> pair_count_o=0x00000000.
- Assert rst_i between clock edges while 3 pairs are queued -> all outputs are 0 immediately, without waiting for a clock edge.
